ysyx_24110006_ifu: RTL and testbench

YSYX_24110006_IFU -- requirements
Module: ysyx_24110006_ifu

---
 rtl/ysyx_24110006_ifu.sv | 126 ++++++++++++
 tb/tb_ysyx_24110006_ifu.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110006_ifu.sv
// Instruction fetch unit: issues one read per redirect from writeback,
// returns the fetched word plus its decoded immediate to decode.
module ysyx_24110006_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_valid,
   input  logic [31:0] i_pc,
   output logic        o_arvalid,
   output logic [31:0] o_araddr,
   input  logic        i_arready,
   input  logic        i_rvalid,
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_rresp,
   output logic        o_rready,
   output logic        o_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_imm,
   output logic [31:0] o_pc,
   output logic        o_err
);

   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [1:0]  OKAY   = 2'b00;

   typedef enum logic [1:0] {S_AR, S_R, S_OUT, S_WAIT} state_t;

   state_t      state, state_nx;
   logic [31:0] pc;
   logic        misaligned;
   logic        capture;
   logic [31:0] inst_nx;
   logic        err_nx;

   assign misaligned = (pc[1:0] != 2'b00);
   assign o_araddr   = pc;
   assign o_valid    = (state == S_OUT);

   // Immediate extraction by opcode; unknown opcodes yield zero.
   function automatic logic [31:0] decode_imm(input logic [31:0] i);
      logic [31:0] imm;
      imm = 32'h0;
      case (i[6:0])
         7'b0010011, 7'b1100111, 7'b0000011, 7'b1110011:
            imm = {{20{i[31]}}, i[31:20]};
         7'b0110111, 7'b0010111:
            imm = {i[31:12], 12'b0};
         7'b1101111:
            imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         7'b0100011:
            imm = {{20{i[31]}}, i[31:25], i[11:7]};
         7'b1100011:
            imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         7'b0110011:
            imm = {25'b0, i[31:25]};
         default:
            imm = 32'h0;
      endcase
      return imm;
   endfunction

   // State register.
   always_ff @(posedge i_clock) begin
      if (i_reset) state <= S_AR;
      else         state <= state_nx;
   end

   // Next state, bus handshakes, and the word to capture for decode.
   // A misaligned pc never reaches the bus; it faults straight to S_OUT.
   always_comb begin
      state_nx  = state;
      o_arvalid = 1'b0;
      o_rready  = 1'b0;
      capture   = 1'b0;
      inst_nx   = EBREAK;
      err_nx    = 1'b1;
      case (state)
         S_AR: begin
            if (misaligned) begin
               capture  = 1'b1;
               state_nx = S_OUT;
            end else begin
               o_arvalid = 1'b1;
               if (i_arready) state_nx = S_R;
            end
         end
         S_R: begin
            o_rready = 1'b1;
            if (i_rvalid) begin
               capture  = 1'b1;
               state_nx = S_OUT;
               if (i_rresp == OKAY) begin
                  inst_nx = i_rdata;
                  err_nx  = 1'b0;
               end
            end
         end
         S_OUT:   state_nx = S_WAIT;
         S_WAIT:  if (i_valid) state_nx = S_AR;
         default: state_nx = S_AR;
      endcase
   end

   // PC only changes on a redirect accepted while idle.
   always_ff @(posedge i_clock) begin
      if (i_reset)                        pc <= RESET_PC;
      else if (state == S_WAIT && i_valid) pc <= i_pc;
   end

   // Decode-facing outputs, refreshed only when a fetch completes.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_inst <= 32'h0;
         o_imm  <= 32'h0;
         o_pc   <= 32'h0;
         o_err  <= 1'b0;
      end else if (capture) begin
         o_inst <= inst_nx;
         o_imm  <= decode_imm(inst_nx);
         o_pc   <= pc;
         o_err  <= err_nx;
      end
   end

endmodule

// File: tb/tb_ysyx_24110006_ifu.sv
// Randomized bench for the fetch unit against a transaction-level model.
module tb_ysyx_24110006_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_valid;
   logic [31:0] i_pc;
   logic        o_arvalid;
   logic [31:0] o_araddr;
   logic        i_arready;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic [1:0]  i_rresp;
   logic        o_rready;
   logic        o_valid;
   logic [31:0] o_inst;
   logic [31:0] o_imm;
   logic [31:0] o_pc;
   logic        o_err;

   int checks   = 0;
   int failures = 0;

   // model state: current fetch address and last delivered record
   logic [31:0] m_pc, m_inst, m_imm, m_pco;
   logic        m_err;
   logic        prev_vld = 1'b0;

   always #5 i_clock = ~i_clock;

   ysyx_24110006_ifu #(.RESET_PC(RST_PC)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_pc(i_pc),
      .o_arvalid(o_arvalid), .o_araddr(o_araddr), .i_arready(i_arready),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rresp(i_rresp),
      .o_rready(o_rready), .o_valid(o_valid), .o_inst(o_inst),
      .o_imm(o_imm), .o_pc(o_pc), .o_err(o_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // RISC-V immediate rules, built from shifted fields
   function automatic logic [31:0] ref_imm(input logic [31:0] i);
      logic [31:0] sx;
      sx = i[31] ? 32'hFFFF_FFFF : 32'h0;
      case (i[6:0])
         7'b0010011, 7'b1100111, 7'b0000011, 7'b1110011:
            return (sx << 12) | (i >> 20);
         7'b0110111, 7'b0010111:
            return i & 32'hFFFF_F000;
         7'b1101111:
            return (sx << 20) | (((i >> 12) & 32'hFF) << 12) | (((i >> 20) & 32'h1) << 11)
                   | (((i >> 21) & 32'h3FF) << 1);
         7'b0100011:
            return (sx << 12) | ((i >> 25) << 5) | ((i >> 7) & 32'h1F);
         7'b1100011:
            return (sx << 12) | (((i >> 7) & 32'h1) << 11) | (((i >> 25) & 32'h3F) << 5)
                   | (((i >> 8) & 32'hF) << 1);
         7'b0110011:
            return i >> 25;
         default:
            return 32'h0;
      endcase
   endfunction

   // decode strobe must be a single-cycle pulse
   always @(negedge i_clock) begin
      if (o_valid) chk("vld_single", {31'b0, prev_vld}, 32'h0);
      prev_vld <= o_valid;
   end

   task automatic do_reset();
      i_reset = 1'b1;
      @(negedge i_clock);
      @(negedge i_clock);
      chk("rst_valid", {31'b0, o_valid}, 32'h0);
      chk("rst_rready", {31'b0, o_rready}, 32'h0);
      chk("rst_inst", o_inst, 32'h0);
      chk("rst_imm", o_imm, 32'h0);
      chk("rst_pc", o_pc, 32'h0);
      chk("rst_err", {31'b0, o_err}, 32'h0);
      i_reset = 1'b0;
      m_pc = RST_PC; m_inst = 32'h0; m_imm = 32'h0; m_pco = 32'h0; m_err = 1'b0;
      chk("rel_arvalid", {31'b0, o_arvalid}, 32'h1);
      chk("rel_araddr", o_araddr, RST_PC);
   endtask

   task automatic redirect(input logic [31:0] npc);
      i_valid = 1'b1;
      i_pc    = npc;
      @(negedge i_clock);
      i_valid = 1'b0;
      i_pc    = $urandom;
      m_pc    = npc;
   endtask

   // one complete fetch starting in S_AR; noise drives stray rvalid/i_valid
   task automatic fetch(input logic [31:0] rdata, input logic [1:0] rresp,
                        input int ar_wait, input int r_wait, input bit noise);
      if (m_pc[1:0] == 2'b00) begin
         for (int k = 0; k < ar_wait; k++) begin
            chk("ar_hold_vld", {31'b0, o_arvalid}, 32'h1);
            chk("ar_hold_addr", o_araddr, m_pc);
            chk("ar_rready", {31'b0, o_rready}, 32'h0);
            i_arready = 1'b0; i_rvalid = noise; i_rdata = $urandom; i_valid = noise;
            @(negedge i_clock);
         end
         chk("ar_vld", {31'b0, o_arvalid}, 32'h1);
         chk("ar_addr", o_araddr, m_pc);
         i_arready = 1'b1; i_rvalid = noise; i_rdata = $urandom; i_valid = 1'b0;
         @(negedge i_clock);
         i_arready = 1'b0; i_rvalid = 1'b0;
         for (int k = 0; k < r_wait; k++) begin
            chk("r_rready", {31'b0, o_rready}, 32'h1);
            chk("r_no_vld", {31'b0, o_valid}, 32'h0);
            chk("r_no_ar", {31'b0, o_arvalid}, 32'h0);
            i_valid = noise; i_pc = $urandom;
            @(negedge i_clock);
            i_valid = 1'b0;
         end
         chk("r_rready", {31'b0, o_rready}, 32'h1);
         i_rvalid = 1'b1; i_rdata = rdata; i_rresp = rresp; i_valid = noise;
         @(negedge i_clock);
         i_rvalid = 1'b0; i_rresp = 2'b00; i_valid = 1'b0;
         m_err  = (rresp != 2'b00);
         m_inst = m_err ? EBREAK : rdata;
      end else begin
         chk("mis_no_ar", {31'b0, o_arvalid}, 32'h0);
         @(negedge i_clock);
         m_err  = 1'b1;
         m_inst = EBREAK;
      end
      m_imm = ref_imm(m_inst);
      m_pco = m_pc;
      chk("out_vld", {31'b0, o_valid}, 32'h1);
      chk("out_inst", o_inst, m_inst);
      chk("out_imm", o_imm, m_imm);
      chk("out_pc", o_pc, m_pco);
      chk("out_err", {31'b0, o_err}, {31'b0, m_err});
      chk("out_no_ar", {31'b0, o_arvalid}, 32'h0);
      @(negedge i_clock);
      for (int k = 0; k < 1 + int'($urandom_range(0, 2)); k++) begin
         chk("w_no_vld", {31'b0, o_valid}, 32'h0);
         chk("w_no_ar", {31'b0, o_arvalid}, 32'h0);
         chk("w_no_rr", {31'b0, o_rready}, 32'h0);
         chk("w_inst", o_inst, m_inst);
         i_rvalid = noise; i_rdata = $urandom;
         @(negedge i_clock);
      end
      i_rvalid = 1'b0;
   endtask

   logic [6:0]  ops [11] = '{7'b0010011, 7'b1100111, 7'b0000011, 7'b1110011, 7'b0110111,
                             7'b0010111, 7'b1101111, 7'b0100011, 7'b1100011, 7'b0110011,
                             7'b0110000};

   initial begin
      logic [31:0] r, npc, word;
      i_reset = 1'b1; i_valid = 1'b0; i_pc = 32'h0; i_arready = 1'b0;
      i_rvalid = 1'b0; i_rdata = 32'h0; i_rresp = 2'b00;
      @(negedge i_clock);
      do_reset();

      // addi x1, x0, 1 with immediate handshakes
      fetch(32'h0010_0093, 2'b00, 0, 0, 1'b0);
      chk("addi_imm", o_imm, 32'h1);
      chk("addi_pc", o_pc, RST_PC);

      // stalled address phase, then beq x0,x0,-4
      redirect(32'h8000_0004);
      fetch(32'hFE00_0EE3, 2'b00, 5, 0, 1'b0);
      chk("beq_imm", o_imm, 32'hFFFF_FFFC);

      // error response
      redirect(32'h8000_0008);
      fetch(32'h1234_5678, 2'b10, 1, 1, 1'b0);
      chk("slverr_inst", o_inst, EBREAK);

      // misaligned redirect
      redirect(32'h8000_0102);
      fetch(32'h0, 2'b00, 0, 0, 1'b0);
      chk("mis_pc", o_pc, 32'h8000_0102);

      // stray i_valid during read phase is ignored
      redirect(32'h8000_0010);
      fetch(32'h0000_0537, 2'b00, 0, 2, 1'b1);

      // reset while a read is in flight with rvalid on the same edge
      redirect(32'h8000_0020);
      i_arready = 1'b1;
      @(negedge i_clock);
      i_arready = 1'b0;
      i_reset = 1'b1; i_rvalid = 1'b1; i_rdata = 32'h0010_0093;
      @(negedge i_clock);
      i_reset = 1'b0; i_rvalid = 1'b0;
      chk("rst_mid_vld", {31'b0, o_valid}, 32'h0);
      chk("rst_mid_addr", o_araddr, RST_PC);
      chk("rst_mid_arv", {31'b0, o_arvalid}, 32'h1);
      chk("rst_mid_inst", o_inst, 32'h0);
      m_pc = RST_PC; m_inst = 32'h0;
      // late rvalid in S_AR must not complete anything
      i_rvalid = 1'b1;
      @(negedge i_clock);
      i_rvalid = 1'b0;
      chk("late_rvalid", {31'b0, o_valid}, 32'h0);
      fetch(32'h0040_0113, 2'b00, 0, 0, 1'b0);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         r   = $urandom;
         npc = r & ~32'h3;
         if (r[4:2] == 3'b000) npc[1:0] = r[1:0] | 2'b01;
         redirect(npc);
         r    = $urandom;
         word = {r[31:7], ops[$urandom_range(0, 10)]};
         fetch(word, ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
